// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect/control inputs, instruction-memory port and decode-side outputs of the fetch stage
interface fetch_queue_if #(parameter int WIDTH = 16, parameter int DEPTH = 4);
  logic [WIDTH-1:0] NextPC, ImemAddr, ImemData, Instr, IncPC;
  logic Flush, Exception, Rti, Halt, Stall, ImemEn, ImemReady, Valid, Halted;
  logic [$clog2(DEPTH+1)-1:0] Count;
  modport master (
    output NextPC, Flush, Exception, Rti, Halt, Stall, ImemData, ImemReady,
    input  ImemAddr, ImemEn, Instr, IncPC, Valid, Halted, Count
  );
  modport slave (
    input  NextPC, Flush, Exception, Rti, Halt, Stall, ImemData, ImemReady,
    output ImemAddr, ImemEn, Instr, IncPC, Valid, Halted, Count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC register plus DEPTH-entry instruction queue with flush/exception/rti redirects.
// Optional FETCH_EXC_EN enables EPC, Exception and Rti; otherwise Flush is the only redirect.
module fetch_queue_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [WIDTH-1:0] EXC_VEC = 16'h0002,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, pc_inc;
  logic [WIDTH-1:0] ins_q [DEPTH];
  logic [WIDTH-1:0] inc_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic halt_q, halt_d, exc, rti, redir, valid, pop, en, push;
`ifdef FETCH_EXC_EN
  assign exc = bus.Exception;
  assign rti = bus.Rti;
  always_ff @(posedge clk) epc_q <= rst ? '0 : exc ? bus.NextPC : epc_q;
`else
  logic unused_exc;
  assign unused_exc = ^{bus.Exception, bus.Rti};
  assign exc = 1'b0;
  assign rti = 1'b0;
  assign epc_q = '0;
`endif
  always_comb begin
    valid = cnt_q != '0;
    redir = exc | rti | bus.Flush;
    pop = valid & ~bus.Stall;
    en = ~rst & ~halt_q & ~redir & ((cnt_q < CW'(DEPTH)) | pop);
    push = en & bus.ImemReady;
    pc_inc = pc_q + WIDTH'(PC_INC);
    pc_d = exc ? EXC_VEC : rti ? epc_q : bus.Flush ? bus.NextPC : push ? pc_inc : pc_q;
    rd_d = redir ? '0 : rd_q + AW'(pop);
    wr_d = redir ? '0 : wr_q + AW'(push);
    cnt_d = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
    halt_d = halt_q | (bus.Halt & ~redir);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      halt_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      halt_q <= halt_d;
    end
  end
  // queue storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_q] <= bus.ImemData;
      inc_q[wr_q] <= pc_inc;
    end
  end
  assign bus.ImemAddr = pc_q;
  assign bus.ImemEn = en;
  assign bus.Instr = valid ? ins_q[rd_q] : NOP_INSTR;
  assign bus.IncPC = valid ? inc_q[rd_q] : '0;
  assign bus.Valid = valid;
  assign bus.Halted = halt_q & ~valid;
  assign bus.Count = cnt_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed test-plan phases plus random traffic against a queue-based reference model
module tb_fetch_queue_stage;
  localparam int DEPTH = 4;
  typedef struct { logic [15:0] ins, inc; } ent_t;
  logic clk, rst;
  int checks = 0, errors = 0;
  ent_t q[$];
  logic [15:0] m_pc, m_epc;
  logic m_halt;
  fetch_queue_if #(.WIDTH(16), .DEPTH(DEPTH)) bus ();
  fetch_queue_stage #(.WIDTH(16), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic rs, st, rdy, fl, ex, rt, hl, input logic [15:0] np);
    logic exc_e, rti_e, redir, en, pop;
    ent_t e;
    rst = rs; bus.Stall = st; bus.ImemReady = rdy; bus.Flush = fl;
    bus.Exception = ex; bus.Rti = rt; bus.Halt = hl; bus.NextPC = np;
    #1 bus.ImemData = memf(bus.ImemAddr);
    #1;
`ifdef FETCH_EXC_EN
    exc_e = ex; rti_e = rt & ~ex;
`else
    exc_e = 1'b0; rti_e = 1'b0;
`endif
    redir = exc_e | rti_e | fl;
    pop = q.size() > 0 && !st;
    en = !rs && !m_halt && !redir && (q.size() < DEPTH || pop);
    chk("addr", bus.ImemAddr, m_pc);
    chk("en", bus.ImemEn, en);
    chk("valid", bus.Valid, q.size() > 0);
    chk("count", bus.Count, q.size());
    chk("instr", bus.Instr, q.size() > 0 ? q[0].ins : 16'h0800);
    chk("incpc", bus.IncPC, q.size() > 0 ? q[0].inc : 16'h0000);
    chk("halted", bus.Halted, m_halt && q.size() == 0);
    if (rs) begin
      q.delete(); m_pc = '0; m_epc = '0; m_halt = 1'b0;
    end else begin
      if (redir) begin
        q.delete();
        if (exc_e) begin m_epc = np; m_pc = 16'h0002; end
        else if (rti_e) m_pc = m_epc;
        else m_pc = np;
      end else begin
        if (pop) void'(q.pop_front());
        if (en && rdy) begin
          e.ins = memf(m_pc); e.inc = m_pc + 16'd2;
          q.push_back(e);
          m_pc = m_pc + 16'd2;
        end
      end
      if (hl && !redir) m_halt = 1'b1;
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; bus.Stall = 0; bus.ImemReady = 0; bus.Flush = 0; bus.Exception = 0;
    bus.Rti = 0; bus.Halt = 0; bus.NextPC = '0; bus.ImemData = '0;
    m_pc = '0; m_epc = '0; m_halt = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("stream_cnt", bus.Count, 1);
    repeat (6) step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("full_cnt", bus.Count, 4);
    repeat (8) step(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 16'h0100);
    chk("flush_addr", bus.ImemAddr, 16'h0100);
    chk("flush_cnt", bus.Count, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("flush_inc", bus.IncPC, 16'h0102);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 16'h0040);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 16'hFFFE);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("wrap_inc", bus.IncPC, 16'h0000);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("halted_set", bus.Halted, 1);
    step(0, 0, 1, 1, 0, 0, 0, 16'h0200);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("halt_clr", bus.Halted, 0);
    for (int i = 0; i < 3000; i++) begin
      step(m_halt && $urandom_range(0, 20) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 30) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0,
           16'($urandom) & 16'hFFFE);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
